// File: rtl/step_sequencer.sv
// step_sequencer: multi-cycle time_step generator for the CPU control path,
// plus HALT push-button synchronizer/debouncer and debug counters.
//
// Parameters:
//   MAX_STEP  highest legal time_step (<= 15)
//   DEBOUNCE  consecutive stable synchronized cycles to change halt_button (>= 1)
//   CNT_W     width of instr_count
// Ports:
//   clk              single clock, rising edge
//   reset_all_n      asynchronous active-low reset
//   run              1 = advance time_step, 0 = hold (HALT wait)
//   step_reset       end-of-instruction restart request
//   halt_button_raw  asynchronous push-button, active high
//   time_step        current step
//   halt_button      synchronized, debounced button level
//   resume_pulse     one-cycle pulse after each 0->1 of halt_button
//   instr_count      number of step_reset events since reset (wraps)
//   step_timeout     sticky: time_step reached MAX_STEP with run still high
module step_sequencer #(
  parameter int unsigned MAX_STEP = 15,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_all_n,
  input  logic             run,
  input  logic             step_reset,
  input  logic             halt_button_raw,
  output logic [3:0]       time_step,
  output logic             halt_button,
  output logic             resume_pulse,
  output logic [CNT_W-1:0] instr_count,
  output logic             step_timeout
);

  // Debounce counter only ever needs to reach DEBOUNCE-1.
  localparam int unsigned DbW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE - 1);
  localparam logic [3:0] MaxStep = 4'(MAX_STEP);

  logic [3:0]       r_step;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             r_sync1;
  logic             r_sync2;
  logic [DbW-1:0]   r_db_cnt;
  logic             r_halt;
  logic             r_pulse;

  logic [3:0]       w_step_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_timeout_nxt;
  logic [DbW-1:0]   w_db_nxt;
  logic             w_halt_nxt;
  logic             w_rise;

  // Step counter: restart beats hold, hold beats advance.
  always_comb begin
    w_step_nxt    = r_step;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = r_timeout;
    if (step_reset) begin
      w_step_nxt = 4'd0;
      w_cnt_nxt  = r_cnt + CNT_W'(1);
    end else if (run) begin
      if (r_step < MaxStep) begin
        w_step_nxt = r_step + 4'd1;
      end else begin
        w_timeout_nxt = 1'b1;
      end
    end
  end

  // Debounce: count edges of disagreement; any agreement clears the count.
  always_comb begin
    w_db_nxt   = '0;
    w_halt_nxt = r_halt;
    if (r_sync2 != r_halt) begin
      if (r_db_cnt == DbLast) begin
        w_halt_nxt = r_sync2;
      end else begin
        w_db_nxt = r_db_cnt + DbW'(1);
      end
    end
  end

  assign w_rise = w_halt_nxt & ~r_halt;

  always_ff @(posedge clk or negedge reset_all_n) begin
    if (!reset_all_n) begin
      r_step    <= 4'd0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_db_cnt  <= '0;
      r_halt    <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_step    <= w_step_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
      r_sync1   <= halt_button_raw;
      r_sync2   <= r_sync1;
      r_db_cnt  <= w_db_nxt;
      r_halt    <= w_halt_nxt;
      // Registered alongside halt_button so the pulse lines up with the new level.
      r_pulse   <= w_rise;
    end
  end

  assign time_step    = r_step;
  assign instr_count  = r_cnt;
  assign step_timeout = r_timeout;
  assign halt_button  = r_halt;
  assign resume_pulse = r_pulse;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: table of directed vectors, hand-written corner
// sequences (async reset, counter wrap) and randomized stimulus against a
// behavioural model.
module tb_step_sequencer;

  localparam int MaxStep = 15;
  localparam int Deb     = 4;
  localparam int CntW    = 16;

  logic            clk = 1'b0;
  logic            reset_all_n;
  logic            run;
  logic            step_reset;
  logic            halt_button_raw;
  logic [3:0]      time_step;
  logic            halt_button;
  logic            resume_pulse;
  logic [CntW-1:0] instr_count;
  logic            step_timeout;

  always #5 clk = ~clk;

  step_sequencer #(
    .MAX_STEP(MaxStep),
    .DEBOUNCE(Deb),
    .CNT_W   (CntW)
  ) dut (
    .clk            (clk),
    .reset_all_n    (reset_all_n),
    .run            (run),
    .step_reset     (step_reset),
    .halt_button_raw(halt_button_raw),
    .time_step      (time_step),
    .halt_button    (halt_button),
    .resume_pulse   (resume_pulse),
    .instr_count    (instr_count),
    .step_timeout   (step_timeout)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit use_model = 0;
  int m_step, m_cnt;
  bit m_to, m_hb, m_pl;
  bit raw_hist[$];  // raw level sampled at each edge since reset
  bit s2_hist[$];   // synchronized level seen by the debouncer at each edge

  task automatic model_reset();
    m_step = 0; m_cnt = 0; m_to = 0; m_hb = 0; m_pl = 0;
    raw_hist.delete();
    s2_hist.delete();
  endtask

  task automatic model_edge(input bit r, input bit sr, input bit raw);
    bit s2, all_diff;
    if (sr) begin
      m_step = 0;
      m_cnt  = (m_cnt + 1) % (1 << CntW);
    end else if (r) begin
      if (m_step < MaxStep) m_step++;
      else m_to = 1;
    end
    // Two-flop delay: the debouncer sees the raw level from two edges back.
    s2 = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 1'b0;
    raw_hist.push_back(raw);
    if (raw_hist.size() > 2) void'(raw_hist.pop_front());
    s2_hist.push_back(s2);
    if (s2_hist.size() > Deb) void'(s2_hist.pop_front());
    // Output flips once the last Deb observations all disagree with it.
    m_pl = 0;
    if (s2_hist.size() == Deb) begin
      all_diff = 1;
      foreach (s2_hist[j]) if (s2_hist[j] == m_hb) all_diff = 0;
      if (all_diff) begin
        m_hb = !m_hb;
        m_pl = m_hb;
      end
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".time_step"},    32'(time_step),    32'(m_step));
    chk({tag, ".instr_count"},  32'(instr_count),  32'(m_cnt));
    chk({tag, ".step_timeout"}, 32'(step_timeout), 32'(m_to));
    chk({tag, ".halt_button"},  32'(halt_button),  32'(m_hb));
    chk({tag, ".resume_pulse"}, 32'(resume_pulse), 32'(m_pl));
  endtask

  // ---------------- drive helpers ----------------
  task automatic cycle(input bit r, input bit sr, input bit raw);
    run = r;
    step_reset = sr;
    halt_button_raw = raw;
    @(posedge clk);
    if (use_model) model_edge(r, sr, raw);
    #1;
  endtask

  // Called 1 time unit after a rising edge; release lands well before the next.
  task automatic do_reset();
    run = 0; step_reset = 0; halt_button_raw = 0;
    reset_all_n = 0;
    #3;
    reset_all_n = 1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit run, sr, raw;
    int st, cnt;
    bit to, hb, pl;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit r, input bit sr, input bit raw, input int st, input int cnt,
                     input bit to, input bit hb, input bit pl);
    vec_t v;
    v.run = r; v.sr = sr; v.raw = raw; v.st = st; v.cnt = cnt;
    v.to = to; v.hb = hb; v.pl = pl;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    int c = 0;
    // Four instructions restarted at step 3: 1,2,3,0 repeating, no gap.
    for (int i = 0; i < 4; i++) begin
      for (int k = 1; k <= 3; k++) add(1, 0, 0, k, c, 0, 0, 0);
      c++;
      add(1, 1, 0, 0, c, 0, 0, 0);
    end
    // HALT wait at step 3 for 10 cycles, then restart while run=0.
    for (int k = 1; k <= 3; k++) add(1, 0, 0, k, c, 0, 0, 0);
    for (int k = 0; k < 10; k++) add(0, 0, 0, 3, c, 0, 0, 0);
    c++;
    add(0, 1, 0, 0, c, 0, 0, 0);
    // Button glitch of 3 cycles: no change.
    for (int k = 0; k < 3; k++) add(0, 0, 1, 0, c, 0, 0, 0);
    for (int k = 0; k < 8; k++) add(0, 0, 0, 0, c, 0, 0, 0);
    // Button pressed: level rises at edge 6 with a single pulse.
    for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, c, 0, k >= 6, k == 6);
    // Button released: level falls at edge 6, no pulse.
    for (int k = 1; k <= 8; k++) add(0, 0, 0, 0, c, 0, k < 6, 0);
    // Free run to MAX_STEP, timeout the edge after, restart keeps it sticky.
    for (int k = 1; k <= 16; k++) add(1, 0, 0, (k < MaxStep) ? k : MaxStep, c, k == 16, 0, 0);
    c++;
    add(1, 1, 0, 0, c, 1, 0, 0);
    add(1, 0, 0, 1, c, 1, 0, 0);
  endtask

  // ---------------- main ----------------
  initial begin
    bit r, sr, raw;
    int seg;
    reset_all_n = 0;
    run = 0; step_reset = 0; halt_button_raw = 0;
    @(posedge clk);
    #1;
    chk("rst.time_step",    32'(time_step),    0);
    chk("rst.instr_count",  32'(instr_count),  0);
    chk("rst.step_timeout", 32'(step_timeout), 0);
    chk("rst.halt_button",  32'(halt_button),  0);
    chk("rst.resume_pulse", 32'(resume_pulse), 0);
    reset_all_n = 1;

    build_table();
    foreach (vecs[i]) begin
      cycle(vecs[i].run, vecs[i].sr, vecs[i].raw);
      chk($sformatf("vec%0d.time_step", i),    32'(time_step),    32'(vecs[i].st));
      chk($sformatf("vec%0d.instr_count", i),  32'(instr_count),  32'(vecs[i].cnt));
      chk($sformatf("vec%0d.step_timeout", i), 32'(step_timeout), 32'(vecs[i].to));
      chk($sformatf("vec%0d.halt_button", i),  32'(halt_button),  32'(vecs[i].hb));
      chk($sformatf("vec%0d.resume_pulse", i), 32'(resume_pulse), 32'(vecs[i].pl));
    end

    // Asynchronous reset mid-instruction with halt_button high.
    do_reset();
    for (int k = 1; k <= 7; k++) cycle(1, 0, 1);
    chk("mid.time_step_pre",   32'(time_step),   7);
    chk("mid.halt_button_pre", 32'(halt_button), 1);
    halt_button_raw = 0;
    reset_all_n = 0;
    #1;
    chk("mid.time_step",    32'(time_step),    0);
    chk("mid.halt_button",  32'(halt_button),  0);
    chk("mid.instr_count",  32'(instr_count),  0);
    chk("mid.step_timeout", 32'(step_timeout), 0);
    chk("mid.resume_pulse", 32'(resume_pulse), 0);
    #2;
    reset_all_n = 1;
    cycle(1, 0, 0);
    chk("mid.restart_step", 32'(time_step),   1);
    chk("mid.restart_hb",   32'(halt_button), 0);

    // instr_count wrap.
    do_reset();
    repeat (65535) cycle(1, 1, 0);
    chk("wrap.instr_count_max", 32'(instr_count), 32'h0000_ffff);
    chk("wrap.time_step",       32'(time_step),   0);
    cycle(1, 1, 0);
    chk("wrap.instr_count_zero", 32'(instr_count), 0);

    // Randomized stimulus against the model.
    use_model = 1;
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      seg = 0;
      raw = 0;
      for (int n = 0; n < 800; n++) begin
        if (seg == 0) begin
          raw = 1'($urandom_range(0, 1));
          seg = $urandom_range(1, 10);
        end
        seg--;
        r  = ($urandom_range(0, 9) != 0);
        sr = ($urandom_range(0, 6 + 8 * blk) == 0);
        cycle(r, sr, raw);
        model_check($sformatf("rnd%0d_%0d", blk, n));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Multi-cycle step generator that sits directly upstream of the CPU control path. It produces the `time_step` count the control path decodes, holds it while the control path deasserts `run` on a HALT instruction, and restarts it when the control path signals end-of-instruction. It also conditions the raw HALT push-button into the clean `halt_button` level the control path consumes, and keeps a retired-instruction count and a stuck-sequence flag for debug.

## Interface
- `MAX_STEP`, default 15: highest legal `time_step`; must be ≤15.
- `DEBOUNCE`, default 4: consecutive stable synchronized cycles required to change `halt_button`; must be ≥1.
- `CNT_W`, default 16: width of `instr_count`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_all_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  from control path; 1 = advance `time_step`, 0 = hold (HALT wait).
- `step_reset`  in  1  from control path; end-of-instruction restart request.
- `halt_button_raw`  in  1  asynchronous board push-button, active high.
- `time_step`  out  4  current step, to control path.
- `halt_button`  out  1  synchronized, debounced button level, to control path.
- `resume_pulse`  out  1  one-cycle pulse on each 0→1 transition of `halt_button`.
- `instr_count`  out  CNT_W  number of `step_reset` events since reset.
- `step_timeout`  out  1  sticky: `time_step` reached `MAX_STEP` without a restart.

## Operation
- Reset (`reset_all_n`=0, asynchronous): `time_step`=0, `halt_button`=0, `resume_pulse`=0, `instr_count`=0, `step_timeout`=0, synchronizer flops=0, debounce counter=0. Reset mid-instruction discards the step in progress.
- Step counter, per rising edge, priority order:
  - `step_reset`=1 → `time_step`←0 regardless of `run`; `instr_count`←`instr_count`+1 (wraps all-ones→0).
  - else `run`=0 → hold.
  - else `time_step`<`MAX_STEP` → increment.
  - else (`time_step`=`MAX_STEP`, `run`=1) → hold at `MAX_STEP`, `step_timeout`←1.
- `step_timeout` cleared only by reset; `step_reset` does not clear it.
- `step_reset` and `run`=0 in the same cycle: restart wins.
- HALT path: `halt_button_raw` → two-flop synchronizer (`s1`, `s2`) → debounce.
  - Debounce counter increments each edge while `s2`≠`halt_button`; clears to 0 whenever `s2`=`halt_button`.
  - When counter = `DEBOUNCE`−1 and `s2`≠`halt_button`: `halt_button`←`s2`, counter←0.
  - Any disagreement shorter than `DEBOUNCE` cycles at `s2` produces no output change.
- `resume_pulse`=1 for exactly the cycle after `halt_button` goes 0→1; 0 otherwise, including on 1→0 transitions.

## Timing
- All outputs registered; no combinational input→output paths.
- `step_reset` sampled high at edge N → `time_step`=0 after edge N; `instr_count` updated at the same edge.
- From `time_step`=0 with `run`=1, `time_step`=k after k edges (k ≤ `MAX_STEP`).
- The control path observes restart as 0,1,2,3,… with no gap cycle.
- Button: with raw stable from edge 1 (first edge sampling the new level), `halt_button` changes at edge `DEBOUNCE`+2 (edge 6 at default). `resume_pulse` is high in the cycle after that edge.
- Reset deassertion is not synchronized internally. The system provides synchronous release; the first counting edge is the first edge after release.

## Test plan
- Reset then `run`=1, no `step_reset` → `time_step` 0,1,…,15 on successive edges, holds at 15. `step_timeout` rises at the edge after reaching 15; `step_reset` then gives 0 with `step_timeout` still 1.
- `run`=1, `step_reset` pulsed whenever `time_step`=3, for 4 instructions → sequence 0..3 repeats with no gap; `instr_count`=4; `step_timeout`=0.
- At `time_step`=3, drop `run` for 10 cycles → `time_step` stays 3. Assert `step_reset` while `run`=0 → 0 next edge and `instr_count` increments.
- Raw button high 3 cycles then low (default `DEBOUNCE`=4) → `halt_button` stays 0 and no `resume_pulse`. Raw high held → `halt_button`=1 at edge 6 and `resume_pulse` high for exactly one cycle. Raw low held → `halt_button`=0 at edge 6 with no pulse.
- Preload `instr_count`=0xFFFF via 65535 restarts, one more `step_reset` → 0x0000.
- Assert `reset_all_n`=0 between edges at `time_step`=7, `halt_button`=1 → all outputs 0 immediately, before the next edge. After release the counter restarts from 0.
